// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared widths, ID/EX payload layout and skid-stage state encoding
package mips_pipe_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int ALUOP_W = 3;
  localparam int FUNCT_W = 6;

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               reg_write;
    logic [DATA_W-1:0]  data1;
    logic [DATA_W-1:0]  data2;
    logic [REG_W-1:0]   rd;
    logic [FUNCT_W-1:0] funct;
  } idex_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } idex_state_t;

endpackage

// File: rtl/idex_payload_reg.sv
// rtl/idex_payload_reg.sv - load-enabled payload register, cleared by reset
module idex_payload_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/idex_skid_stage.sv
// rtl/idex_skid_stage.sv - ID/EX stage with valid/ready handshake, 2-entry skid buffer and flush
// Optional IDEX_SKID_PERF_EN adds saturating stall_cnt/flush_cnt outputs.
module idex_skid_stage #(
  parameter int DATA_W  = mips_pipe_pkg::DATA_W,
  parameter int REG_W   = mips_pipe_pkg::REG_W,
  parameter int ALUOP_W = mips_pipe_pkg::ALUOP_W,
  parameter int FUNCT_W = mips_pipe_pkg::FUNCT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] in_alu_op,
  input  logic               in_reg_write,
  input  logic [DATA_W-1:0]  in_data1,
  input  logic [DATA_W-1:0]  in_data2,
  input  logic [REG_W-1:0]   in_rd,
  input  logic [FUNCT_W-1:0] in_funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ALUOP_W-1:0] out_alu_op,
  output logic               out_reg_write,
  output logic [DATA_W-1:0]  out_data1,
  output logic [DATA_W-1:0]  out_data2,
  output logic [REG_W-1:0]   out_rd,
  output logic [FUNCT_W-1:0] out_funct
`ifdef IDEX_SKID_PERF_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        flush_cnt
`endif
);

  import mips_pipe_pkg::*;

  localparam int PW = ALUOP_W + 1 + 2 * DATA_W + REG_W + FUNCT_W;

  idex_state_t   state, state_nxt;
  logic          accept, pop;
  logic          load_main, load_skid, main_from_skid;
  logic [PW-1:0] in_pl, main_d, main_q, skid_q;
  logic          main_reg_write;

  assign in_pl     = {in_alu_op, in_reg_write, in_data1, in_data2, in_rd, in_funct};
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (accept && pop) begin
            load_main = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can happen
          if (pop) begin
            state_nxt      = ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // in_ready comes straight from a flop so EX back-pressure never reaches ID combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != FULL);
    end
  end

  assign main_d = main_from_skid ? skid_q : in_pl;

  idex_payload_reg #(.W(PW)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (load_main),
    .d    (main_d),
    .q    (main_q)
  );

  idex_payload_reg #(.W(PW)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (load_skid),
    .d    (in_pl),
    .q    (skid_q)
  );

  assign {out_alu_op, main_reg_write, out_data1, out_data2, out_rd, out_funct} = main_q;
  assign out_reg_write = main_reg_write & out_valid;

`ifdef IDEX_SKID_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (flush && flush_cnt != 16'hFFFF) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
